dispatch_ctrl: RTL and testbench
================================

// Module: dispatch_ctrl
// PURPOSE
//  Credit-based dispatch scheduler between rename and ROB / issue queue.
//  - Tracks free ROB and issue-queue entries.
//  - Drives in-order ready to both rename slots and allocates ROB ids with a wrap bit.
//  - Owns the flush/recovery state machine that blocks dispatch while the back end is restored.
// PARAMETERS
//  ROB_DEPTH      64  ROB entries, power of 2
//  IDX_W          6   log2(ROB_DEPTH); ROB ids are IDX_W+1 bits, MSB = wrap bit
//  ISQ_DEPTH      8   issue-queue entries
//  ISQ_CW         4   credit width, holds 0..ISQ_DEPTH
//  FLUSH_HOLD     2   cycles dispatch stays blocked after a flush
// PORTS
//  clock                   in   1        core clock
//  reset                   in   1        asynchronous, active-high
//  instr0_valid            in   1        rename slot0 valid
//  instr1_valid            in   1        rename slot1 valid
//  disp2rn_instr0_ready    out  1        slot0 accepted
//  disp2rn_instr1_ready    out  1        slot1 accepted
//  instr0_fire             out  1        instr0_valid & disp2rn_instr0_ready; gates ROB/ISQ write enables
//  instr1_fire             out  1        instr1_valid & disp2rn_instr1_ready
//  instr0_robid            out  IDX_W+1  ROB id for slot0 (= enq_ptr)
//  instr1_robid            out  IDX_W+1  ROB id for slot1 (= enq_ptr+1)
//  rob2disp_commit_cnt     in   2        entries retired this cycle, 0..2
//  isq2disp_issue_cnt      in   2        entries issued this cycle, 0..2
//  rob2disp_deq_ptr        in   IDX_W+1  ROB head pointer, used on flush
//  flush_valid             in   1        pipeline flush
//  flush_robid             in   IDX_W+1  first ROB id to be killed; new enq_ptr
//  rob_free                out  IDX_W+1  registered free ROB count, debug
//  isq_free                out  ISQ_CW   registered free ISQ count, debug
// BEHAVIOUR
//  - Reset: state=RUN, enq_ptr=0, rob_free=ROB_DEPTH, isq_free=ISQ_DEPTH, hold_cnt=0.
//    All ready/fire outputs are 0 while reset is asserted.
//  - Combinational readiness, using registered credits only:
//    - ready0 = RUN & !flush_valid & rob_free>=1 & isq_free>=1
//    - ready1 = ready0 & instr0_valid & rob_free>=2 & isq_free>=2 (strictly in order)
//  - Credits freed in cycle N (commit/issue) become usable in N+1, never in the same cycle.
//  - Credit update each cycle, saturation-free:
//    - rob_free += commit_cnt - fires
//    - isq_free += issue_cnt - fires
//    - fires = instr0_fire + instr1_fire
//  - Pointer update: enq_ptr += fires, modulo 2^(IDX_W+1); the wrap bit toggles on index wrap.
//  - FSM:
//    - RUN --flush_valid--> HOLD
//    - HOLD: hold_cnt counts FLUSH_HOLD-1 down to 0; at 0 -> RUN. A flush in HOLD restarts the count.
//  - On flush, for the flush cycle and onward:
//    - no fire
//    - enq_ptr <= flush_robid
//    - rob_free <= ROB_DEPTH - (flush_robid - rob2disp_deq_ptr)
//    - isq_free <= ISQ_DEPTH (ISQ wiped)
//    - commit/issue counts in that cycle are ignored
//  - Flush and valid in the same cycle: flush wins and ready is 0.
//  - Full boundary: with rob_free==1, only slot0 may fire. With rob_free==0, both readys are 0.
//  - Overflow guard: a sim-only assertion fires if a credit exceeds its depth or goes below 0.
//  - Reset mid-HOLD returns to RUN and full credits immediately.
// CONFIGURATION
//  DISPATCH_CTRL_PERF_EN:
//  - Defined: adds 32-bit wrapping outputs
//    - perf_rob_stall: cycles with instr0_valid, RUN, rob_free==0
//    - perf_isq_stall: cycles with instr0_valid, RUN, rob_free>0, isq_free==0
//    - perf_flush_cyc: cycles not in RUN
//    All three reset to 0.
//  - Undefined: the ports and counters are absent and there is no other change.
// STRUCTURE
//  - Package dispatch_pkg: disp_state_e {RUN, HOLD}, ROB_DEPTH/IDX_W/ISQ_DEPTH defaults, robid_t typedef.
//  - Sub-module disp_credit_cnt (params DEPTH, W):
//    - ports: inc[1:0], dec[1:0], load, load_val, count
//    - instantiated once for the ROB and once for the ISQ
//  - FSM, pointer logic and perf counters stay in the top.
// TESTING
//  1. Reset, then both valid every cycle with no commit/issue:
//     - 4 cycles of dual fire, robids 0..7
//     - isq_free=0 afterwards, readys 0
//  2. ISQ_DEPTH=8, issue_cnt=2 every cycle from cycle 5:
//     - steady dual dispatch
//     - credit freed in N is first used in N+1
//  3. 63 dispatched, 1 free: both valid -> only slot0 fires (robid 63).
//     Next: wrap, next robid=64 (wrap bit=1, index 0) after commit.
//  4. flush_valid with flush_robid=10, deq_ptr=4, valid high:
//     - no fire that cycle
//     - rob_free=58, isq_free=8
//     - 2 HOLD cycles, then the first fire gets robid 10
//  5. Second flush during HOLD -> hold restarts.
//     Reset asserted in HOLD -> RUN, credits full, enq_ptr 0.
//  6. With DISPATCH_CTRL_PERF_EN: hold rob_free=0 for 5 cycles with valid -> perf_rob_stall=5.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types and default sizing for the rename-to-backend dispatch controller.
// Optional perf counters in dispatch_ctrl are enabled by DISPATCH_CTRL_PERF_EN.
package dispatch_pkg;

  localparam int unsigned ROB_DEPTH  = 64;
  localparam int unsigned IDX_W      = 6;
  localparam int unsigned ISQ_DEPTH  = 8;
  localparam int unsigned ISQ_CW     = 4;
  localparam int unsigned FLUSH_HOLD = 2;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } disp_state_e;

  typedef logic [IDX_W:0] robid_t;

  function automatic logic [1:0] fire_sum(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/disp_credit_cnt.sv
// Free-entry credit counter: adds returned credits, subtracts consumed ones, reloads on flush.
module disp_credit_cnt #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:0]   inc,
  input  logic [1:0]   dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  // One extra bit so an underflow shows up as a value above DEPTH.
  logic [W:0] next_ext;

  always_comb begin
    next_ext = {1'b0, count} + (W+1)'(inc) - (W+1)'(dec);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= W'(DEPTH);
    end else if (load) begin
      assert ({1'b0, load_val} <= (W+1)'(DEPTH));
      count <= load_val;
    end else begin
      assert (next_ext <= (W+1)'(DEPTH));
      count <= next_ext[W-1:0];
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Credit-based dispatch scheduler with ROB id allocation and flush recovery FSM.
// Define DISPATCH_CTRL_PERF_EN to add stall/flush performance counters.
module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int unsigned ROB_DEPTH  = dispatch_pkg::ROB_DEPTH,
  parameter int unsigned IDX_W      = dispatch_pkg::IDX_W,
  parameter int unsigned ISQ_DEPTH  = dispatch_pkg::ISQ_DEPTH,
  parameter int unsigned ISQ_CW     = dispatch_pkg::ISQ_CW,
  parameter int unsigned FLUSH_HOLD = dispatch_pkg::FLUSH_HOLD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr0_valid,
  input  logic              instr1_valid,
  output logic              disp2rn_instr0_ready,
  output logic              disp2rn_instr1_ready,
  output logic              instr0_fire,
  output logic              instr1_fire,
  output logic [IDX_W:0]    instr0_robid,
  output logic [IDX_W:0]    instr1_robid,
  input  logic [1:0]        rob2disp_commit_cnt,
  input  logic [1:0]        isq2disp_issue_cnt,
  input  logic [IDX_W:0]    rob2disp_deq_ptr,
  input  logic              flush_valid,
  input  logic [IDX_W:0]    flush_robid,
`ifdef DISPATCH_CTRL_PERF_EN
  output logic [31:0]       perf_rob_stall,
  output logic [31:0]       perf_isq_stall,
  output logic [31:0]       perf_flush_cyc,
`endif
  output logic [IDX_W:0]    rob_free,
  output logic [ISQ_CW-1:0] isq_free
);

  localparam int unsigned RW     = IDX_W + 1;
  localparam int unsigned HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

  disp_state_e       state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [RW-1:0]     enq_ptr;
  logic [1:0]        fires;
  logic [RW-1:0]     rob_load;
  logic              in_run;

  // Readiness looks only at registered credits, so same-cycle returns are never reused.
  always_comb begin
    in_run               = (state == RUN);
    disp2rn_instr0_ready = !reset && in_run && !flush_valid &&
                           (rob_free != '0) && (isq_free != '0);
    disp2rn_instr1_ready = disp2rn_instr0_ready && instr0_valid &&
                           (rob_free >= RW'(2)) && (isq_free >= ISQ_CW'(2));
    instr0_fire          = instr0_valid && disp2rn_instr0_ready;
    instr1_fire          = instr1_valid && disp2rn_instr1_ready;
    fires                = fire_sum(instr0_fire, instr1_fire);
    instr0_robid         = enq_ptr;
    instr1_robid         = enq_ptr + RW'(1);
    rob_load             = RW'(ROB_DEPTH) - (flush_robid - rob2disp_deq_ptr);
  end

  disp_credit_cnt #(.DEPTH(ROB_DEPTH), .W(RW)) u_rob_credit (
    .clock    (clock),
    .reset    (reset),
    .inc      (rob2disp_commit_cnt),
    .dec      (fires),
    .load     (flush_valid),
    .load_val (rob_load),
    .count    (rob_free)
  );

  disp_credit_cnt #(.DEPTH(ISQ_DEPTH), .W(ISQ_CW)) u_isq_credit (
    .clock    (clock),
    .reset    (reset),
    .inc      (isq2disp_issue_cnt),
    .dec      (fires),
    .load     (flush_valid),
    .load_val (ISQ_CW'(ISQ_DEPTH)),
    .count    (isq_free)
  );

  // Enqueue pointer; the MSB is the wrap bit and flips naturally on index wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enq_ptr <= '0;
    end else if (flush_valid) begin
      enq_ptr <= flush_robid;
    end else begin
      enq_ptr <= enq_ptr + RW'(fires);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Recovery FSM: any flush (re)starts the hold window.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      RUN: begin
        if (flush_valid) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = HOLD_W'(FLUSH_HOLD - 1);
        end
      end
      HOLD: begin
        if (flush_valid) begin
          hold_cnt_nxt = HOLD_W'(FLUSH_HOLD - 1);
        end else if (hold_cnt == '0) begin
          state_nxt = RUN;
        end else begin
          hold_cnt_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      default: begin
        state_nxt    = RUN;
        hold_cnt_nxt = '0;
      end
    endcase
  end

`ifdef DISPATCH_CTRL_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_rob_stall <= '0;
      perf_isq_stall <= '0;
      perf_flush_cyc <= '0;
    end else begin
      if (instr0_valid && in_run && (rob_free == '0))
        perf_rob_stall <= perf_rob_stall + 32'd1;
      if (instr0_valid && in_run && (rob_free != '0) && (isq_free == '0))
        perf_isq_stall <= perf_isq_stall + 32'd1;
      if (!in_run)
        perf_flush_cyc <= perf_flush_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed scoreboard bench for dispatch_ctrl; perf checks compile with DISPATCH_CTRL_PERF_EN.
module tb_dispatch_ctrl;
  import dispatch_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       instr0_valid, instr1_valid;
  logic       disp2rn_instr0_ready, disp2rn_instr1_ready;
  logic       instr0_fire, instr1_fire;
  robid_t     instr0_robid, instr1_robid;
  logic [1:0] rob2disp_commit_cnt, isq2disp_issue_cnt;
  robid_t     rob2disp_deq_ptr;
  logic       flush_valid;
  robid_t     flush_robid;
  robid_t     rob_free;
  logic [3:0] isq_free;
`ifdef DISPATCH_CTRL_PERF_EN
  logic [31:0] perf_rob_stall, perf_isq_stall, perf_flush_cyc;
`endif

  int     checks = 0;
  int     errors = 0;
  int     mrob, misq;
  robid_t mptr;
  robid_t sb[$];

  always #5 clock = ~clock;

  dispatch_ctrl dut (
    .clock                (clock),
    .reset                (reset),
    .instr0_valid         (instr0_valid),
    .instr1_valid         (instr1_valid),
    .disp2rn_instr0_ready (disp2rn_instr0_ready),
    .disp2rn_instr1_ready (disp2rn_instr1_ready),
    .instr0_fire          (instr0_fire),
    .instr1_fire          (instr1_fire),
    .instr0_robid         (instr0_robid),
    .instr1_robid         (instr1_robid),
    .rob2disp_commit_cnt  (rob2disp_commit_cnt),
    .isq2disp_issue_cnt   (isq2disp_issue_cnt),
    .rob2disp_deq_ptr     (rob2disp_deq_ptr),
    .flush_valid          (flush_valid),
    .flush_robid          (flush_robid),
`ifdef DISPATCH_CTRL_PERF_EN
    .perf_rob_stall       (perf_rob_stall),
    .perf_isq_stall       (perf_isq_stall),
    .perf_flush_cyc       (perf_flush_cyc),
`endif
    .rob_free             (rob_free),
    .isq_free             (isq_free)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Drive one cycle, compare at the falling edge, then advance the model.
  task automatic step(input logic v0, input logic v1, input logic [1:0] cc, input logic [1:0] ic,
                      input logic fl, input robid_t frid, input robid_t dq,
                      input logic e0, input logic e1, input string tag);
    instr0_valid        = v0;
    instr1_valid        = v1;
    rob2disp_commit_cnt = cc;
    isq2disp_issue_cnt  = ic;
    flush_valid         = fl;
    flush_robid         = frid;
    rob2disp_deq_ptr    = dq;
    @(negedge clock);
    chk({tag, ".rob_free"}, 32'(rob_free), 32'(mrob));
    chk({tag, ".isq_free"}, 32'(isq_free), 32'(misq));
    chk({tag, ".fire0"}, 32'(instr0_fire), 32'(e0));
    chk({tag, ".fire1"}, 32'(instr1_fire), 32'(e1));
    if (e0) sb.push_back(mptr);
    if (e1) sb.push_back(mptr + 7'd1);
    if (instr0_fire) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s.robid0 unexpected fire robid=%0d", tag, instr0_robid);
      end else chk({tag, ".robid0"}, 32'(instr0_robid), 32'(sb.pop_front()));
    end
    if (instr1_fire) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s.robid1 unexpected fire robid=%0d", tag, instr1_robid);
      end else chk({tag, ".robid1"}, 32'(instr1_robid), 32'(sb.pop_front()));
    end
    sb.delete();
    if (fl) begin
      mptr = frid;
      mrob = 64 - int'(7'(frid - dq));
      misq = 8;
    end else begin
      mrob = mrob + int'(cc) - int'(e0) - int'(e1);
      misq = misq + int'(ic) - int'(e0) - int'(e1);
      mptr = mptr + 7'(int'(e0) + int'(e1));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset        = 1'b1;
    instr0_valid = 1'b1;
    instr1_valid = 1'b1;
    flush_valid  = 1'b0;
    @(negedge clock);
    chk({tag, ".ready0"}, 32'(disp2rn_instr0_ready), 32'd0);
    chk({tag, ".ready1"}, 32'(disp2rn_instr1_ready), 32'd0);
    chk({tag, ".fire0"}, 32'(instr0_fire), 32'd0);
    chk({tag, ".rob_free"}, 32'(rob_free), 32'd64);
    chk({tag, ".isq_free"}, 32'(isq_free), 32'd8);
    chk({tag, ".robid0"}, 32'(instr0_robid), 32'd0);
`ifdef DISPATCH_CTRL_PERF_EN
    chk({tag, ".perf_flush"}, perf_flush_cyc, 32'd0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    mrob  = 64;
    misq  = 8;
    mptr  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset               = 1'b1;
    instr0_valid        = 1'b0;
    instr1_valid        = 1'b0;
    rob2disp_commit_cnt = '0;
    isq2disp_issue_cnt  = '0;
    rob2disp_deq_ptr    = '0;
    flush_valid         = 1'b0;
    flush_robid         = '0;
    @(posedge clock);
    #1;
    do_reset("reset");

    // Dual dispatch until the ISQ runs dry.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 0, 1, 1, "t1_dual");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t1_isq_empty");

    // Issued credits become usable only on the following cycle.
    step(1, 1, 0, 2, 0, 0, 0, 0, 0, "t2_same_cycle");
    for (int i = 0; i < 4; i++) step(1, 1, 0, 2, 0, 0, 0, 1, 1, "t2_steady");

    // Fill the ROB down to one free entry, then cross the wrap point.
    for (int i = 0; i < 23; i++) step(1, 1, 0, 2, 0, 0, 0, 1, 1, "t3_fill");
    step(1, 0, 0, 1, 0, 0, 0, 1, 0, "t3_single");
    step(1, 1, 0, 1, 0, 0, 0, 1, 0, "t3_one_free");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t3_rob_full");
    step(1, 1, 2, 0, 0, 0, 0, 0, 0, "t3_commit");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, "t3_wrap");

    // Flush with valid high and nonzero commit/issue, then the hold window.
    step(1, 1, 2, 2, 1, 7'd10, 7'd4, 0, 0, "t4_flush");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t4_hold1");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t4_hold2");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, "t4_resume");

    // Re-flush inside HOLD restarts the window.
    step(1, 1, 0, 0, 1, 7'd20, 7'd10, 0, 0, "t5_flush_a");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t5_hold_a");
    step(1, 1, 0, 0, 1, 7'd20, 7'd12, 0, 0, "t5_flush_b");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t5_hold_b1");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t5_hold_b2");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, "t5_resume");

    // Reset asserted while in HOLD.
    step(1, 1, 0, 0, 1, 7'd30, 7'd25, 0, 0, "t5_flush_c");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t5_hold_c");
    do_reset("t5_reset");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, "t5_after_reset");

`ifdef DISPATCH_CTRL_PERF_EN
    for (int i = 0; i < 31; i++) step(1, 1, 0, 2, 0, 0, 0, 1, 1, "t6_fill");
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t6_stall");
    chk("t6.perf_rob_stall", perf_rob_stall, 32'd5);
    chk("t6.perf_isq_stall", perf_isq_stall, 32'd0);
    chk("t6.perf_flush_cyc", perf_flush_cyc, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
